// File: rtl/switch_arb_pkg.sv
// Shared types, constants and helpers for the switch_arbiter_rr core and its picker.
package switch_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Width of an index into n entries; kept at least 1 so degenerate sizes still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker: round-robin scan from a start pointer, or lowest index
// first when mode is set. Ports in excl are never chosen.
module rr_pick
  import switch_arb_pkg::*;
#(
  parameter int N  = 9,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  input  logic          mode,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0]  masked;
  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  assign masked = req & ~excl;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = '0;
    pos    = '0;
    for (int i = 0; i < N; i++) begin
      // Candidate i positions after the pointer, wrapped back into 0..N-1.
      sum = mode ? (IW+1)'(i) : {1'b0, start} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      pos = sum[IW-1:0];
      if (!any && masked[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/switch_arbiter_rr.sv
// N-port switch arbiter: round-robin or fixed-priority grant with bounded tenure and a
// registered forward of the owner's serial data bit.
module switch_arbiter_rr
  import switch_arb_pkg::*;
#(
  parameter int NUM_PORTS = 9,
  parameter int MAX_HOLD  = 16,
  parameter int PRIO_MODE = 0
) (
  input  logic                              core_clock,
  input  logic                              core_rst,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              din,
  output logic [NUM_PORTS-1:0]              gnt,
  output logic [idx_width(NUM_PORTS)-1:0]   gnt_id,
  output logic                              busy,
  output logic                              dout,
  output logic                              dout_vld,
  output logic                              timeout
);

  localparam int              IW        = idx_width(NUM_PORTS);
  localparam int              CW        = idx_width(MAX_HOLD);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [IW-1:0]   LAST_PORT = IW'(NUM_PORTS - 1);
  localparam logic            FIXED     = (PRIO_MODE == PRIO_FIXED);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_d;
  logic [IW-1:0]        gnt_id_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        hold_q, hold_d;
  logic                 timeout_d;
  logic                 take;

  logic [NUM_PORTS-1:0] excl;
  logic [NUM_PORTS-1:0] pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  // The current owner is excluded so release and timeout hand over to someone else.
  assign excl = (state_q == GRANT) ? gnt : '0;
  assign busy = (state_q == GRANT);

  rr_pick #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .start  (ptr_q),
    .excl   (excl),
    .mode   (FIXED),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    take      = 1'b0;
    unique case (state_q)
      IDLE: take = pick_any;
      GRANT: begin
        if (!req[gnt_id]) begin
          take = pick_any;
          if (!pick_any) begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_LAST) begin
          // Tenure exhausted: hand over if anyone else waits, else restart the count.
          timeout_d = 1'b1;
          take      = pick_any;
          if (!pick_any) hold_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (take) begin
      state_d  = GRANT;
      gnt_d    = pick_oh;
      gnt_id_d = pick_idx;
      hold_d   = '0;
      ptr_d    = (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge core_clock) begin
    if (core_rst) begin
      state_q  <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      timeout  <= 1'b0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      gnt_id   <= gnt_id_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      timeout  <= timeout_d;
      dout_vld <= (state_q == GRANT);
      dout     <= (state_q == GRANT) ? din[gnt_id] : 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_arbiter_rr.sv
// Scoreboard bench for switch_arbiter_rr: a round-robin instance (MAX_HOLD=4) and a
// fixed-priority instance (MAX_HOLD=16) share one clock and reset.
module tb_switch_arbiter_rr;

  localparam int NP = 9;
  typedef logic [16:0] snap_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req_a, din_a, gnt_a;
  logic [NP-1:0] req_b, din_b, gnt_b;
  logic [3:0]    gnt_id_a, gnt_id_b;
  logic          busy_a, dout_a, dout_vld_a, timeout_a;
  logic          busy_b, dout_b, dout_vld_b, timeout_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_arbiter_rr #(.NUM_PORTS(NP), .MAX_HOLD(4), .PRIO_MODE(0)) u_rr (
    .core_clock (clk),
    .core_rst   (rst),
    .req        (req_a),
    .din        (din_a),
    .gnt        (gnt_a),
    .gnt_id     (gnt_id_a),
    .busy       (busy_a),
    .dout       (dout_a),
    .dout_vld   (dout_vld_a),
    .timeout    (timeout_a)
  );

  switch_arbiter_rr #(.NUM_PORTS(NP), .MAX_HOLD(16), .PRIO_MODE(1)) u_fp (
    .core_clock (clk),
    .core_rst   (rst),
    .req        (req_b),
    .din        (din_b),
    .gnt        (gnt_b),
    .gnt_id     (gnt_id_b),
    .busy       (busy_b),
    .dout       (dout_b),
    .dout_vld   (dout_vld_b),
    .timeout    (timeout_b)
  );

  function automatic snap_t snap_a();
    return {gnt_a, gnt_id_a, busy_a, dout_a, dout_vld_a, timeout_a};
  endfunction

  function automatic snap_t snap_b();
    return {gnt_b, gnt_id_b, busy_b, dout_b, dout_vld_b, timeout_b};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    req_a = '0; din_a = '0;
    req_b = '0; din_b = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    snap_t         sq[$];
    logic [NP-1:0] gq[$];
    snap_t         es;
    logic [NP-1:0] eg;
    rst   = 1'b1;
    req_a = '0; din_a = '0;
    req_b = '0; din_b = '0;
    repeat (2) @(negedge clk);
    sq.push_back('0); sq.push_back('0);
    es = sq.pop_front();
    n_checks++;
    if (snap_a() !== es) begin n_fail++; $display("FAIL reset_rr: got %h expected %h", snap_a(), es); end
    es = sq.pop_front();
    n_checks++;
    if (snap_b() !== es) begin n_fail++; $display("FAIL reset_fp: got %h expected %h", snap_b(), es); end

    // Grant port 3, then reset in the middle of its tenure.
    rst   = 1'b0;
    req_a = 9'h008;
    din_a = 9'h008;
    gq.push_back(9'h008);
    @(negedge clk);
    eg = gq.pop_front();
    n_checks++;
    if (gnt_a !== eg) begin n_fail++; $display("FAIL reset_first_gnt: got %h expected %h", gnt_a, eg); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (dout_vld_a !== 1'b1 || dout_a !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_data: got vld=%b dout=%b expected 1 1", dout_vld_a, dout_a);
    end
    rst = 1'b1;
    sq.push_back('0);
    @(negedge clk);
    es = sq.pop_front();
    n_checks++;
    if (snap_a() !== es) begin n_fail++; $display("FAIL reset_mid_tenure: got %h expected %h", snap_a(), es); end
    rst = 1'b0;
    gq.push_back(9'h008);
    @(negedge clk);
    eg = gq.pop_front();
    n_checks++;
    if (gnt_a !== eg || gnt_id_a !== 4'd3 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL regrant_after_reset: got gnt=%h id=%0d busy=%b expected %h 3 1", gnt_a, gnt_id_a, busy_a, eg);
    end
    req_a = '0;
    din_a = '0;
    @(negedge clk);
    n_checks++;
    if (gnt_a !== '0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL release_to_idle: got gnt=%h busy=%b expected 0 0", gnt_a, busy_a);
    end
  endtask

  task automatic test_fairness();
    int            exp_q[$];
    int            owner, len, cyc, e;
    logic [NP-1:0] eoh;
    do_reset();
    for (int i = 0; i <= NP; i++) exp_q.push_back(i % NP);
    req_a = 9'h1FF;
    owner = -1; len = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (owner >= 0 && !busy_a) begin
        n_checks++; n_fail++;
        $display("FAIL rr_bubble: busy dropped at cycle %0d expected 1", cyc);
      end
      if (busy_a && (owner < 0 || int'(gnt_id_a) != owner)) begin
        e   = exp_q.pop_front();
        eoh = NP'(1) << e;
        n_checks++;
        if (gnt_a !== eoh || gnt_id_a !== 4'(e)) begin
          n_fail++; $display("FAIL rr_order: got gnt=%h id=%0d expected %h %0d", gnt_a, gnt_id_a, eoh, e);
        end
        if (owner >= 0) begin
          n_checks++;
          if (len !== 4) begin n_fail++; $display("FAIL rr_tenure: port %0d got %0d cycles expected 4", owner, len); end
          n_checks++;
          if (timeout_a !== 1'b1) begin n_fail++; $display("FAIL rr_timeout_pulse: got %b expected 1", timeout_a); end
        end
        owner = e;
        len   = 1;
      end else if (busy_a) begin
        len++;
        n_checks++;
        if (timeout_a !== 1'b0) begin n_fail++; $display("FAIL rr_stray_timeout: got %b expected 0", timeout_a); end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_budget: got %0d grants pending expected 0", exp_q.size()); end
    req_a = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [NP-1:0] stim [3] = '{9'h004, 9'h024, 9'h020};
    logic [NP-1:0] expv [3] = '{9'h004, 9'h004, 9'h020};
    logic [NP-1:0] gq[$];
    logic [NP-1:0] eg;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_a = stim[i];
      gq.push_back(expv[i]);
      @(negedge clk);
      eg = gq.pop_front();
      n_checks++;
      if (gnt_a !== eg || busy_a !== 1'b1) begin
        n_fail++; $display("FAIL handover_step%0d: got gnt=%h busy=%b expected %h 1", i, gnt_a, busy_a, eg);
      end
    end
    n_checks++;
    if (timeout_a !== 1'b0 || gnt_id_a !== 4'd5) begin
      n_fail++; $display("FAIL handover_release: got timeout=%b id=%0d expected 0 5", timeout_a, gnt_id_a);
    end
    req_a = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_data();
    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic dq[$];
    logic ed;
    do_reset();
    req_a = 9'h010;
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1 || dout_vld_a !== 1'b0) begin
      n_fail++; $display("FAIL data_vld_lag: got busy=%b vld=%b expected 1 0", busy_a, dout_vld_a);
    end
    for (int i = 0; i < 6; i++) begin
      din_a    = NP'($urandom);
      din_a[4] = pat[i];
      dq.push_back(pat[i]);
      @(negedge clk);
      ed = dq.pop_front();
      n_checks++;
      if (dout_a !== ed || dout_vld_a !== 1'b1) begin
        n_fail++; $display("FAIL data_bit%0d: got dout=%b vld=%b expected %b 1", i, dout_a, dout_vld_a, ed);
      end
    end
    req_a = '0;
    din_a = NP'($urandom);
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || dout_vld_a !== 1'b1) begin
      n_fail++; $display("FAIL data_vld_tail: got busy=%b vld=%b expected 0 1", busy_a, dout_vld_a);
    end
    @(negedge clk);
    n_checks++;
    if (dout_vld_a !== 1'b0 || dout_a !== 1'b0) begin
      n_fail++; $display("FAIL data_idle: got vld=%b dout=%b expected 0 0", dout_vld_a, dout_a);
    end
    din_a = '0;
  endtask

  task automatic test_sole_timeout();
    logic tq[$];
    logic et;
    do_reset();
    req_b = 9'h080;
    for (int i = 0; i < 40; i++) begin
      tq.push_back(i == 16 || i == 32);
      @(negedge clk);
      et = tq.pop_front();
      n_checks++;
      if (gnt_b !== 9'h080) begin n_fail++; $display("FAIL sole_gnt cycle %0d: got %h expected 080", i, gnt_b); end
      n_checks++;
      if (timeout_b !== et) begin n_fail++; $display("FAIL sole_timeout cycle %0d: got %b expected %b", i, timeout_b, et); end
    end
    req_b = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    int            own_q[$];
    logic          to_q[$];
    int            owner, len, cyc, e;
    logic          et;
    logic [NP-1:0] eoh;
    do_reset();
    own_q.push_back(5); to_q.push_back(1'b0);
    own_q.push_back(1); to_q.push_back(1'b1);
    own_q.push_back(5); to_q.push_back(1'b0);
    req_b = 9'h0A0;
    owner = -1; len = 0; cyc = 0;
    while (own_q.size() > 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy_b && (owner < 0 || int'(gnt_id_b) != owner)) begin
        e   = own_q.pop_front();
        et  = to_q.pop_front();
        eoh = NP'(1) << e;
        n_checks++;
        if (gnt_b !== eoh) begin n_fail++; $display("FAIL fixed_owner: got %h expected %h", gnt_b, eoh); end
        n_checks++;
        if (timeout_b !== et) begin n_fail++; $display("FAIL fixed_timeout: got %b expected %b", timeout_b, et); end
        if (e == 1) begin
          n_checks++;
          if (len !== 16) begin n_fail++; $display("FAIL fixed_tenure: got %0d cycles expected 16", len); end
        end
        owner = e;
        len   = 1;
      end else if (busy_b) begin
        len++;
      end
      if (owner == 5 && len == 3 && own_q.size() == 2) req_b = 9'h0A2;
      if (owner == 1 && len == 3) req_b = 9'h0A0;
    end
    n_checks++;
    if (own_q.size() != 0) begin n_fail++; $display("FAIL fixed_budget: got %0d grants pending expected 0", own_q.size()); end
    req_b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_b !== 1'b0) begin n_fail++; $display("FAIL fixed_idle: got busy=%b expected 0", busy_b); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_back_to_back();
    test_data();
    test_sole_timeout();
    test_fixed_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
